peripheral_spram_axi4_master: RTL and testbench

- AXI4 initiator that drives the SPRAM AXI4 bridge slave from a simple command/stream interface.
- Converts one command at a time into an AW/W/B or AR/R transaction, with INCR bursts of 1..256 beats.
- Used as the synthesizable traffic source in the SPRAM validation bench, and as the host-side port for MPSoC tiles.

---
 rtl/peripheral_spram_axi4_pkg.sv | 25 ++
 rtl/peripheral_spram_axi4_master_watchdog.sv | 41 ++++
 rtl/peripheral_spram_axi4_master.sv | 278 +++++++++++++++++++++++++++
 tb/tb_peripheral_spram_axi4_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_spram_axi4_pkg.sv
// Shared definitions for the SPRAM AXI4 master: FSM state encoding, the AXI
// burst and response codes, and the beat-size helper.
package peripheral_spram_axi4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI AxSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned strb_width);
        return 3'($clog2(strb_width));
    endfunction

endpackage

// File: rtl/peripheral_spram_axi4_master_watchdog.sv
// Stall watchdog for the SPRAM AXI4 master. Counts cycles spent waiting in a
// non-idle state without a handshake and raises a sticky flag once the wait
// reaches TIMEOUT_CYCLES. It only observes; the master keeps waiting.
module peripheral_spram_axi4_master_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic handshake,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_reg;
    logic        timeout_reg;

    // Stall counter: cleared in idle and on any handshake, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 16'd0;
        end else if (!active || handshake) begin
            count_reg <= 16'd0;
        end else if (count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // Sticky flag: set on the stalled cycle that brings the count to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
        end else if (active && !handshake && (count_reg == LIMIT)) begin
            timeout_reg <= 1'b1;
        end
    end

    assign timeout = timeout_reg;

endmodule

// File: rtl/peripheral_spram_axi4_master.sv
// AXI4 initiator for the SPRAM bridge: turns one command at a time into an
// AW/W/B or AR/R INCR burst of 1..256 beats, with write data and read data
// carried over simple valid/ready streams.
// Optional: define PERIPHERAL_SPRAM_AXI4_MASTER_TIMEOUT_EN to enable the
// stall watchdog driving timeout_o; otherwise timeout_o is tied low.
module peripheral_spram_axi4_master
    import peripheral_spram_axi4_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_USER_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // command interface
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id_i,
    // write-data stream
    input  logic                      wdat_valid_i,
    output logic                      wdat_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] wdat_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] wdat_strb_i,
    // read-data stream
    output logic                      rdat_valid_o,
    input  logic                      rdat_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] rdat_data_o,
    output logic [1:0]                rdat_resp_o,
    output logic                      rdat_last_o,
    // status
    output logic                      wrsp_valid_o,
    output logic [1:0]                wrsp_resp_o,
    output logic                      id_err_o,
    output logic                      timeout_o,
    // AW channel
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    output logic                      axi_aw_lock,
    output logic [3:0]                axi_aw_cache,
    output logic [2:0]                axi_aw_prot,
    output logic [3:0]                axi_aw_qos,
    output logic [3:0]                axi_aw_region,
    output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,
    // W channel
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic [AXI_USER_WIDTH-1:0] axi_w_user,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,
    // B channel
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,
    // AR channel
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    output logic                      axi_ar_lock,
    output logic [3:0]                axi_ar_cache,
    output logic [2:0]                axi_ar_prot,
    output logic [3:0]                axi_ar_qos,
    output logic [3:0]                axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,
    // R channel
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    state_t                    state_reg;
    logic [AXI_ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]                len_reg;
    logic [AXI_ID_WIDTH-1:0]   id_reg;
    logic [7:0]                beat_cnt_reg;
    logic                      aw_valid_reg;
    logic                      ar_valid_reg;
    logic                      cmd_ready_reg;
    logic                      wrsp_valid_reg;
    logic [1:0]                wrsp_resp_reg;
    logic                      id_err_reg;

    logic in_w;
    logic in_r;
    logic w_hs;
    logic r_hs;
    logic last_beat;

    assign in_w      = (state_reg == ST_W);
    assign in_r      = (state_reg == ST_R);
    assign last_beat = (beat_cnt_reg == len_reg);
    assign w_hs      = axi_w_valid && axi_w_ready;
    assign r_hs      = axi_r_valid && axi_r_ready;

    // Main transaction FSM; all control outputs except the stream pass-throughs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            len_reg        <= 8'd0;
            id_reg         <= '0;
            beat_cnt_reg   <= 8'd0;
            aw_valid_reg   <= 1'b0;
            ar_valid_reg   <= 1'b0;
            cmd_ready_reg  <= 1'b0;
            wrsp_valid_reg <= 1'b0;
            wrsp_resp_reg  <= RESP_OKAY;
            id_err_reg     <= 1'b0;
        end else begin
            wrsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_reg) begin
                        addr_reg      <= cmd_addr_i;
                        len_reg       <= cmd_len_i;
                        id_reg        <= cmd_id_i;
                        cmd_ready_reg <= 1'b0;
                        if (cmd_we_i) begin
                            aw_valid_reg <= 1'b1;
                            state_reg    <= ST_AW;
                        end else begin
                            ar_valid_reg <= 1'b1;
                            state_reg    <= ST_AR;
                        end
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ST_AW: begin
                    if (axi_aw_ready) begin
                        aw_valid_reg <= 1'b0;
                        beat_cnt_reg <= 8'd0;
                        state_reg    <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        // Stop counting on the last beat so len=255 never wraps.
                        if (last_beat) begin
                            state_reg <= ST_B;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (axi_b_valid) begin
                        wrsp_valid_reg <= 1'b1;
                        wrsp_resp_reg  <= axi_b_resp;
                        if (axi_b_id != id_reg) begin
                            id_err_reg <= 1'b1;
                        end
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (axi_ar_ready) begin
                        ar_valid_reg <= 1'b0;
                        state_reg    <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        if (axi_r_id != id_reg) begin
                            id_err_reg <= 1'b1;
                        end
                        if (axi_r_last) begin
                            cmd_ready_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_reg;
    assign wrsp_valid_o = wrsp_valid_reg;
    assign wrsp_resp_o  = wrsp_resp_reg;
    assign id_err_o     = id_err_reg;

    // AW and AR share the captured command; only the valid differs.
    assign axi_aw_id     = id_reg;
    assign axi_aw_addr   = addr_reg;
    assign axi_aw_len    = len_reg;
    assign axi_aw_size   = axi_size(AXI_STRB_WIDTH);
    assign axi_aw_burst  = BURST_INCR;
    assign axi_aw_lock   = 1'b0;
    assign axi_aw_cache  = 4'b0000;
    assign axi_aw_prot   = 3'b000;
    assign axi_aw_qos    = 4'd0;
    assign axi_aw_region = 4'd0;
    assign axi_aw_user   = '0;
    assign axi_aw_valid  = aw_valid_reg;

    assign axi_ar_id     = id_reg;
    assign axi_ar_addr   = addr_reg;
    assign axi_ar_len    = len_reg;
    assign axi_ar_size   = axi_size(AXI_STRB_WIDTH);
    assign axi_ar_burst  = BURST_INCR;
    assign axi_ar_lock   = 1'b0;
    assign axi_ar_cache  = 4'b0000;
    assign axi_ar_prot   = 3'b000;
    assign axi_ar_qos    = 4'd0;
    assign axi_ar_region = 4'd0;
    assign axi_ar_user   = '0;
    assign axi_ar_valid  = ar_valid_reg;

    // Write stream is gated by the W state, so no beat can leave before the AW handshake.
    assign axi_w_valid  = in_w && wdat_valid_i;
    assign wdat_ready_o = in_w && axi_w_ready;
    assign axi_w_data   = wdat_data_i;
    assign axi_w_strb   = wdat_strb_i;
    assign axi_w_last   = in_w && last_beat;
    assign axi_w_user   = '0;

    assign axi_b_ready  = (state_reg == ST_B);

    // Read stream: downstream ready back-pressures R directly.
    assign axi_r_ready  = in_r && rdat_ready_i;
    assign rdat_valid_o = in_r && axi_r_valid;
    assign rdat_data_o  = axi_r_data;
    assign rdat_resp_o  = axi_r_resp;
    assign rdat_last_o  = axi_r_last;

`ifdef PERIPHERAL_SPRAM_AXI4_MASTER_TIMEOUT_EN
    logic any_hs;
    assign any_hs = ((state_reg == ST_AW) && axi_aw_ready) ||
                    w_hs ||
                    ((state_reg == ST_B) && axi_b_valid) ||
                    ((state_reg == ST_AR) && axi_ar_ready) ||
                    r_hs;

    peripheral_spram_axi4_master_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .active    (state_reg != ST_IDLE),
        .handshake (any_hs),
        .timeout   (timeout_o)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, axi_b_user, axi_r_user};
`else
    assign timeout_o = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, axi_b_user, axi_r_user, (TIMEOUT_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_peripheral_spram_axi4_master.sv
// Bench for peripheral_spram_axi4_master: a behavioural AXI slave with a
// memory, a reference memory updated as write data is driven, and a read
// scoreboard queue checked beat by beat as the DUT delivers data.
module tb_peripheral_spram_axi4_master;

    localparam int IDW = 10;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int UW  = 10;
    localparam int TO  = 16;
`ifdef PERIPHERAL_SPRAM_AXI4_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           cmd_valid = 0, cmd_ready, cmd_we = 0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [7:0]     cmd_len = '0;
    logic [IDW-1:0] cmd_id = '0;
    logic           wdat_valid = 0, wdat_ready;
    logic [DW-1:0]  wdat_data = '0;
    logic [SW-1:0]  wdat_strb = '0;
    logic           rdat_valid, rdat_ready = 0, rdat_last;
    logic [DW-1:0]  rdat_data;
    logic [1:0]     rdat_resp;
    logic           wrsp_valid, id_err, timeout;
    logic [1:0]     wrsp_resp;

    logic [IDW-1:0] aw_id, ar_id;
    logic [AW-1:0]  aw_addr, ar_addr;
    logic [7:0]     aw_len, ar_len;
    logic [2:0]     aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]     aw_burst, ar_burst;
    logic           aw_lock, ar_lock, aw_valid, ar_valid;
    logic [3:0]     aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [UW-1:0]  aw_user, ar_user, w_user;
    logic           aw_ready = 0, ar_ready = 0;
    logic [DW-1:0]  w_data;
    logic [SW-1:0]  w_strb;
    logic           w_last, w_valid, w_ready = 0;
    logic [IDW-1:0] b_id = '0, r_id = '0;
    logic [1:0]     b_resp = '0, r_resp = '0;
    logic [UW-1:0]  b_user = '0, r_user = '0;
    logic           b_valid = 0, b_ready;
    logic [DW-1:0]  r_data = '0;
    logic           r_last = 0, r_valid = 0, r_ready;

    peripheral_spram_axi4_master #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_STRB_WIDTH(SW), .AXI_USER_WIDTH(UW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready),
        .wdat_data_i(wdat_data), .wdat_strb_i(wdat_strb),
        .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_data_o(rdat_data),
        .rdat_resp_o(rdat_resp), .rdat_last_o(rdat_last),
        .wrsp_valid_o(wrsp_valid), .wrsp_resp_o(wrsp_resp),
        .id_err_o(id_err), .timeout_o(timeout),
        .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
        .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
        .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos), .axi_aw_region(aw_region),
        .axi_aw_user(aw_user), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
        .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_user(w_user),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready),
        .axi_b_id(b_id), .axi_b_resp(b_resp), .axi_b_user(b_user), .axi_b_valid(b_valid),
        .axi_b_ready(b_ready),
        .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
        .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
        .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos), .axi_ar_region(ar_region),
        .axi_ar_user(ar_user), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
        .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
        .axi_r_user(r_user), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ slave model
    int          aw_stall = 0;
    int          ar_stall = 0;
    int          b_id_force = -1;
    logic [1:0]  b_resp_force = 2'b00;
    bit [63:0]   slv_mem [logic [63:0]];
    logic [63:0] s_waddr, s_raddr;
    logic [IDW-1:0] s_awid, s_arid;
    logic [7:0]  s_rlen;
    int          s_wbeat, s_rbeat, aw_wait, ar_wait;
    bit          r_open, b_due, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [7:0]  cap_aw_len;
    logic [2:0]  cap_aw_size;
    logic [1:0]  cap_aw_burst;
    logic [63:0] cap_aw_addr;
    logic [IDW-1:0] cap_aw_id;

    task automatic slave_idle();
        aw_ready = 0; ar_ready = 0; w_ready = 1; b_valid = 0; r_valid = 0; r_last = 0;
        aw_wait = 0; ar_wait = 0; r_open = 0; b_due = 0;
    endtask

    // Slave: sample handshakes mid-cycle, update outputs just after the rising edge.
    initial begin
        slave_idle();
        forever begin
            @(negedge clk);
            hs_aw = aw_valid && aw_ready;
            hs_w  = w_valid && w_ready;
            hs_b  = b_valid && b_ready;
            hs_ar = ar_valid && ar_ready;
            hs_r  = r_valid && r_ready;
            if (hs_aw) begin
                s_waddr = aw_addr; s_awid = aw_id; s_wbeat = 0;
                cap_aw_len = aw_len; cap_aw_size = aw_size; cap_aw_burst = aw_burst;
                cap_aw_addr = aw_addr; cap_aw_id = aw_id;
            end
            if (hs_w) begin
                logic [63:0] k;
                bit [63:0] old;
                k = (s_waddr >> 3) + 64'(s_wbeat);
                old = slv_mem.exists(k) ? slv_mem[k] : 64'd0;
                for (int b = 0; b < SW; b++)
                    if (w_strb[b]) old[b*8 +: 8] = w_data[b*8 +: 8];
                slv_mem[k] = old;
                s_wbeat++;
                if (w_last) b_due = 1;
            end
            if (hs_ar) begin
                s_raddr = ar_addr; s_arid = ar_id; s_rlen = ar_len; s_rbeat = 0; r_open = 1;
            end
            if (hs_r) begin
                if (r_last) r_open = 0;
                s_rbeat++;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                slave_idle();
                continue;
            end
            if (hs_aw) begin aw_ready = 0; aw_wait = 0; end
            else if (aw_valid) begin aw_wait++; aw_ready = (aw_wait >= aw_stall); end
            if (hs_ar) begin ar_ready = 0; ar_wait = 0; end
            else if (ar_valid) begin ar_wait++; ar_ready = (ar_wait >= ar_stall); end
            if (hs_b) b_valid = 0;
            if (b_due) begin
                b_valid = 1;
                b_id = (b_id_force >= 0) ? IDW'(b_id_force) : s_awid;
                b_resp = b_resp_force;
                b_due = 0;
            end
            if (r_open) begin
                logic [63:0] rk;
                rk = (s_raddr >> 3) + 64'(s_rbeat);
                r_valid = 1;
                r_data = slv_mem.exists(rk) ? slv_mem[rk] : 64'd0;
                r_last = (s_rbeat == int'(s_rlen));
                r_id = s_arid;
                r_resp = 2'b00;
            end else begin
                r_valid = 0; r_last = 0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    typedef struct { logic [63:0] data; logic last; logic [1:0] resp; } rd_exp_t;
    rd_exp_t     exp_rd[$];
    logic [1:0]  exp_wr[$];
    bit [63:0]   ref_mem [logic [63:0]];

    task automatic send_cmd(input logic we, input logic [63:0] addr, input int len, input logic [IDW-1:0] id);
        bit got = 0;
        cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_len = 8'(len); cmd_id = id;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
            @(posedge clk); #1;
            if (got) break;
        end
        cmd_valid = 0;
        if (!got) check_eq("cmd_accept", 64'(got), 64'd1);
    endtask

    task automatic drive_beat(input int i, input int len, input logic [63:0] d, input logic [7:0] strb, input logic [63:0] addr);
        bit got = 0;
        logic [63:0] k;
        bit [63:0] old;
        wdat_valid = 1; wdat_data = d; wdat_strb = strb;
        k = (addr >> 3) + 64'(i);
        old = ref_mem.exists(k) ? ref_mem[k] : 64'd0;
        for (int b = 0; b < SW; b++)
            if (strb[b]) old[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[k] = old;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wdat_ready) begin
                got = 1;
                check_eq($sformatf("w_last[%0d]", i), 64'(w_last), 64'(i == len));
            end
            @(posedge clk); #1;
            if (got) break;
        end
        if (!got) check_eq($sformatf("w_beat_accept[%0d]", i), 64'(got), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input logic [IDW-1:0] id,
                            input logic [63:0] base, input logic [7:0] strb,
                            input logic [1:0] exp_resp, input int hold);
        bit got = 0;
        send_cmd(1'b1, addr, len, id);
        exp_wr.push_back(exp_resp);
        wdat_valid = 1; wdat_data = base; wdat_strb = strb;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("aw_valid_hold", 64'(aw_valid), 64'd1);
            check_eq("aw_addr_hold", aw_addr, addr);
            check_eq("w_before_aw", 64'(w_valid), 64'd0);
            @(posedge clk); #1;
        end
        for (int i = 0; i <= len; i++) drive_beat(i, len, base + 64'(i), strb, addr);
        wdat_valid = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wrsp_valid) begin
                got = 1;
                check_eq("wrsp_resp", 64'(wrsp_resp), 64'(exp_wr.pop_front()));
            end
            @(posedge clk); #1;
            if (got) break;
        end
        if (!got) check_eq("wrsp_seen", 64'(got), 64'd1);
        @(negedge clk);
        check_eq("wrsp_one_cycle", 64'(wrsp_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input logic [IDW-1:0] id,
                           input bit toggle, input bit to_check);
        bit got_last = 0;
        send_cmd(1'b0, addr, len, id);
        for (int i = 0; i <= len; i++) begin
            logic [63:0] k;
            k = (addr >> 3) + 64'(i);
            exp_rd.push_back('{data: (ref_mem.exists(k) ? ref_mem[k] : 64'd0),
                               last: (i == len), resp: 2'b00});
        end
        if (to_check) begin
            repeat (5) @(negedge clk);
            check_eq("timeout_early", 64'(timeout), 64'd0);
            repeat (15) @(negedge clk);
            check_eq("timeout_flag", 64'(timeout), 64'(TO_EN));
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5000 && !got_last; c++) begin
            rdat_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rdat_valid && rdat_ready) begin
                if (exp_rd.size() == 0) begin
                    check_eq("rd_unexpected", 64'(rdat_valid), 64'd0);
                end else begin
                    rd_exp_t e;
                    e = exp_rd.pop_front();
                    check_eq("rd_data", rdat_data, e.data);
                    check_eq("rd_last", 64'(rdat_last), 64'(e.last));
                    check_eq("rd_resp", 64'(rdat_resp), 64'(e.resp));
                    if (rdat_last) got_last = 1;
                end
            end
            @(posedge clk); #1;
        end
        rdat_ready = 0;
        check_eq("rd_beats_left", 64'(exp_rd.size()), 64'd0);
        if (!got_last) check_eq("rd_complete", 64'(got_last), 64'd1);
        exp_rd.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: bench did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_aw_valid", 64'(aw_valid), 64'd0);
        check_eq("rst_ar_valid", 64'(ar_valid), 64'd0);
        check_eq("rst_w_valid", 64'(w_valid), 64'd0);
        check_eq("rst_wrsp_valid", 64'(wrsp_valid), 64'd0);
        check_eq("rst_id_err", 64'(id_err), 64'd0);
        check_eq("rst_timeout", 64'(timeout), 64'd0);
        check_eq("rst_aw_addr", aw_addr, 64'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // 1: single-beat write
        do_write(64'h40, 0, 10'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00, 0);
        check_eq("t1_aw_len", 64'(cap_aw_len), 64'd0);
        check_eq("t1_aw_size", 64'(cap_aw_size), 64'd3);
        check_eq("t1_aw_burst", 64'(cap_aw_burst), 64'd1);
        check_eq("t1_aw_addr", cap_aw_addr, 64'h40);
        check_eq("t1_aw_id", 64'(cap_aw_id), 64'd3);
        check_eq("t1_id_err", 64'(id_err), 64'd0);
        // 2: read back
        do_read(64'h40, 0, 10'd3, 1'b0, 1'b0);
        // partial-strobe write merged into an existing word
        do_write(64'h48, 0, 10'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 0);
        do_write(64'h48, 0, 10'd4, 64'h1111_1111_2222_2222, 8'h0F, 2'b00, 0);
        do_read(64'h48, 0, 10'd4, 1'b0, 1'b0);
        // 3: 16-beat burst, read back with random downstream stalls
        do_write(64'h100, 15, 10'd1, 64'd0, 8'hFF, 2'b00, 0);
        do_read(64'h100, 15, 10'd1, 1'b1, 1'b0);
        // 4: AW held off for 20 cycles
        aw_stall = 20;
        do_write(64'h200, 0, 10'd7, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 15);
        aw_stall = 0;
        do_read(64'h200, 0, 10'd7, 1'b0, 1'b0);
        // maximum burst length
        do_write(64'h1000, 255, 10'd2, 64'hA5A5_0000_0000_0000, 8'hFF, 2'b00, 0);
        do_read(64'h1000, 255, 10'd2, 1'b1, 1'b0);
        check_eq("pre_t5_id_err", 64'(id_err), 64'd0);
        // 5: wrong BID, error response forwarded, flag sticky
        b_id_force = 5; b_resp_force = 2'b10;
        do_write(64'h300, 0, 10'd3, 64'h5555, 8'hFF, 2'b10, 0);
        check_eq("t5_id_err", 64'(id_err), 64'd1);
        b_id_force = -1; b_resp_force = 2'b00;
        do_write(64'h308, 0, 10'd3, 64'h6666, 8'hFF, 2'b00, 0);
        check_eq("t5_id_err_sticky", 64'(id_err), 64'd1);
        // 6: reset during W beat 3 of 8
        send_cmd(1'b1, 64'h800, 7, 10'd9);
        for (int i = 0; i < 3; i++) drive_beat(i, 7, 64'h900 + 64'(i), 8'hFF, 64'h800);
        wdat_valid = 1; wdat_data = 64'h903;
        #2 rst_n = 0;
        #1;
        check_eq("t6_w_valid", 64'(w_valid), 64'd0);
        check_eq("t6_aw_valid", 64'(aw_valid), 64'd0);
        check_eq("t6_ar_valid", 64'(ar_valid), 64'd0);
        check_eq("t6_rdat_valid", 64'(rdat_valid), 64'd0);
        check_eq("t6_wrsp_valid", 64'(wrsp_valid), 64'd0);
        check_eq("t6_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("t6_id_err_clr", 64'(id_err), 64'd0);
        wdat_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t6_cmd_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        do_read(64'h40, 0, 10'd6, 1'b0, 1'b0);
        // AR withheld long enough to trip the watchdog when present
        ar_stall = 30;
        do_read(64'h100, 3, 10'd8, 1'b0, 1'b1);
        ar_stall = 0;
        check_eq("final_id_err", 64'(id_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
